// File: rtl/geiger_run_sequencer.sv
// Timed counting-run sequencer for two Geiger channels: gates fixed windows, latches
// per-window hit counts, accumulates run totals and drives the LED display word.
module geiger_run_sequencer #(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int NUM_RUNS    = 60,
    parameter int CNT_W       = 8,
    parameter int TOT_W       = 16
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             hit0,
    input  logic             hit1,
    input  logic [2:0]       sw,
    output logic             gate,
    output logic             busy,
    output logic             done,
    output logic [7:0]       run_idx,
    output logic [CNT_W-1:0] last0,
    output logic [CNT_W-1:0] last1,
    output logic [TOT_W-1:0] total0,
    output logic [TOT_W-1:0] total1,
    output logic [7:0]       LED
);

    localparam int              CYC_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(GATE_CYCLES - 1);
    localparam logic [7:0]      RUNS     = 8'(NUM_RUNS);

    typedef enum logic [1:0] {
        IDLE,
        GATE,
        LATCH,
        DONE
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CYC_W-1:0] cyc;
    logic [CNT_W-1:0] win0;
    logic [CNT_W-1:0] win1;
    logic [7:0]       run_next;
    logic             seq_start;
    logic             latch_en;
    logic [TOT_W:0]   sum0;
    logic [TOT_W:0]   sum1;
    logic [7:0]       last0_8;
    logic [7:0]       last1_8;
    logic [8:0]       last_sum;
    logic [7:0]       led_next;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge sys_clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: every output of this block gets a default first, so no path through
    // the case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        next_state = state;
        seq_start  = 1'b0;
        latch_en   = 1'b0;
        gate       = (state == GATE);
        busy       = (state == GATE) || (state == LATCH);
        done       = (state == DONE);
        run_next   = run_idx + 8'd1;
        if (abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        next_state = GATE;
                        seq_start  = 1'b1;
                    end
                end
                GATE: begin
                    if (cyc == CYC_LAST) next_state = LATCH;
                end
                LATCH: begin
                    latch_en   = 1'b1;
                    next_state = (run_next == RUNS) ? DONE : GATE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    assign sum0 = {1'b0, total0} + (TOT_W+1)'(win0);
    assign sum1 = {1'b0, total1} + (TOT_W+1)'(win1);

    // An abort in GATE leaves the window counters dirty; the next start clears them.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            cyc     <= '0;
            win0    <= '0;
            win1    <= '0;
            last0   <= '0;
            last1   <= '0;
            total0  <= '0;
            total1  <= '0;
            run_idx <= '0;
        end else if (seq_start) begin
            cyc     <= '0;
            win0    <= '0;
            win1    <= '0;
            total0  <= '0;
            total1  <= '0;
            run_idx <= '0;
        end else if (state == GATE) begin
            cyc <= cyc + 1'b1;
            if (hit0 && (win0 != '1)) win0 <= win0 + 1'b1;
            if (hit1 && (win1 != '1)) win1 <= win1 + 1'b1;
        end else if (latch_en) begin
            last0   <= win0;
            last1   <= win1;
            total0  <= sum0[TOT_W] ? '1 : sum0[TOT_W-1:0];
            total1  <= sum1[TOT_W] ? '1 : sum1[TOT_W-1:0];
            run_idx <= run_next;
            win0    <= '0;
            win1    <= '0;
            cyc     <= '0;
        end
    end

    assign last0_8  = 8'(last0);
    assign last1_8  = 8'(last1);
    assign last_sum = {1'b0, last0_8} + {1'b0, last1_8};

    always_comb begin
        led_next = 8'h00;
        case (sw)
            3'b000: led_next = 8'h00;
            3'b001: led_next = last0_8;
            3'b010: led_next = last1_8;
            3'b011: led_next = last_sum[8:1];
            3'b100: led_next = total0[TOT_W-1 -: 8];
            3'b101: led_next = total1[TOT_W-1 -: 8];
            3'b110: led_next = run_idx;
            3'b111: led_next = {busy, done, gate, 5'b0};
            default: led_next = 8'h00;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) LED <= 8'h00;
        else       LED <= led_next;
    end

endmodule

// File: tb/tb_geiger_run_sequencer.sv
// Randomized scoreboard bench for geiger_run_sequencer: a window-level model predicts
// each latched result, and a monitor compares whenever run_idx advances.
module tb_geiger_run_sequencer;

    localparam int G  = 10;
    localparam int N  = 3;
    localparam int GS = 300;

    logic        sys_clk = 1'b0;
    logic        reset, start, abort, hit0, hit1;
    logic [2:0]  sw;
    logic        gate, busy, done;
    logic [7:0]  run_idx, last0, last1, LED;
    logic [15:0] total0, total1;

    logic        s_start, s_hit1;
    logic        s_gate, s_busy, s_done;
    logic [7:0]  s_run, s_last0, s_last1, s_led;
    logic [15:0] s_total0, s_total1;

    always #5 sys_clk = ~sys_clk;

    geiger_run_sequencer #(.GATE_CYCLES(G), .NUM_RUNS(N), .CNT_W(8), .TOT_W(16)) dut (
        .sys_clk(sys_clk), .reset(reset), .start(start), .abort(abort),
        .hit0(hit0), .hit1(hit1), .sw(sw),
        .gate(gate), .busy(busy), .done(done), .run_idx(run_idx),
        .last0(last0), .last1(last1), .total0(total0), .total1(total1), .LED(LED)
    );

    geiger_run_sequencer #(.GATE_CYCLES(GS), .NUM_RUNS(1), .CNT_W(8), .TOT_W(16)) dut_sat (
        .sys_clk(sys_clk), .reset(reset), .start(s_start), .abort(1'b0),
        .hit0(1'b0), .hit1(s_hit1), .sw(3'b010),
        .gate(s_gate), .busy(s_busy), .done(s_done), .run_idx(s_run),
        .last0(s_last0), .last1(s_last1), .total0(s_total0), .total1(s_total1), .LED(s_led)
    );

    typedef struct {
        int run;
        int last0;
        int last1;
        int total0;
        int total1;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_last0, m_last1, m_total0, m_total1, m_run;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    function automatic int popcount(input logic [G-1:0] p);
        int n = 0;
        for (int i = 0; i < G; i++) n += int'(p[i]);
        return n;
    endfunction

    function automatic logic [7:0] led_model(input int k, input logic [2:0] status);
        case (k)
            1:       return 8'(m_last0);
            2:       return 8'(m_last1);
            3:       return 8'((m_last0 + m_last1) / 2);
            4:       return 8'(m_total0 >> 8);
            5:       return 8'(m_total1 >> 8);
            6:       return 8'(m_run);
            7:       return {status, 5'b0};
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_clear();
        m_last0 = 0; m_last1 = 0; m_total0 = 0; m_total1 = 0; m_run = 0;
    endtask

    // Called at a negedge; afterwards the DUT is in the first GATE cycle.
    task automatic do_start();
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        m_total0 = 0; m_total1 = 0; m_run = 0;
        check("start_total0", total0, 0);
        check("start_run_idx", run_idx, 0);
        check("start_last0_kept", last0, m_last0);
    endtask

    // Drives one gate window plus the dead cycle; abort_at >= 0 aborts on that window cycle.
    task automatic drive_window(input logic [G-1:0] p0, input logic [G-1:0] p1,
                                input logic l0, input logic l1, input int abort_at);
        exp_t e;
        for (int c = 0; c < G; c++) begin
            hit0  = p0[c];
            hit1  = p1[c];
            start = ($urandom_range(0, 3) == 0);
            check("gate_open", {gate, busy, done}, 3'b110);
            if (c == abort_at) begin
                abort = 1'b1;
                @(negedge sys_clk);
                abort = 1'b0; hit0 = 1'b0; hit1 = 1'b0; start = 1'b0;
                return;
            end
            @(negedge sys_clk);
        end
        hit0  = l0;
        hit1  = l1;
        start = 1'b0;
        check("dead_gap", {gate, busy, done}, 3'b010);
        m_last0  = sat(popcount(p0), 255);
        m_last1  = sat(popcount(p1), 255);
        m_total0 = sat(m_total0 + m_last0, 65535);
        m_total1 = sat(m_total1 + m_last1, 65535);
        m_run++;
        e = '{m_run, m_last0, m_last1, m_total0, m_total1};
        sb.push_back(e);
        @(negedge sys_clk);
        hit0 = 1'b0;
        hit1 = 1'b0;
    endtask

    task automatic check_state(input string tag, input logic [2:0] status);
        check({tag, "_status"}, {gate, busy, done}, status);
        check({tag, "_run_idx"}, run_idx, m_run);
        check({tag, "_last0"}, last0, m_last0);
        check({tag, "_last1"}, last1, m_last1);
        check({tag, "_total0"}, total0, m_total0);
        check({tag, "_total1"}, total1, m_total1);
    endtask

    // Monitor: each new nonzero run_idx marks a completed window.
    initial begin
        logic [7:0] prev = 8'd0;
        exp_t       e;
        forever begin
            @(negedge sys_clk);
            if (run_idx != prev && run_idx != 8'd0) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_latch", run_idx, 0);
                end else begin
                    e = sb.pop_front();
                    check("sb_run_idx", run_idx, e.run);
                    check("sb_last0", last0, e.last0);
                    check("sb_last1", last1, e.last1);
                    check("sb_total0", total0, e.total0);
                    check("sb_total1", total1, e.total1);
                end
            end
            prev = run_idx;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]   prev_led;
        logic [G-1:0] p0, p1;
        reset = 1'b1; start = 1'b0; abort = 1'b0; hit0 = 1'b0; hit1 = 1'b0; sw = 3'd0;
        s_start = 1'b0; s_hit1 = 1'b0;
        model_clear();
        repeat (2) @(negedge sys_clk);
        check_state("reset", 3'b000);
        check("reset_led", LED, 0);
        reset = 1'b0;
        @(negedge sys_clk);

        // Four hits per window including the final gate cycle.
        do_start();
        for (int w = 0; w < N; w++) drive_window(10'b1000100101, 10'h000, 1'b0, 1'b0, -1);
        check_state("four_hits_done", 3'b001);
        check("four_hits_total0", total0, 12);

        // Final-cycle hit counts, dead-cycle hit dropped; hit1 held for a full window.
        do_start();
        drive_window(10'b1000000000, 10'h3FF, 1'b1, 1'b1, -1);
        for (int w = 1; w < N; w++) drive_window(G'($urandom), G'($urandom), 1'b1, 1'b1, -1);
        check_state("edge_hits_done", 3'b001);

        // Randomized full sequences.
        for (int r = 0; r < 2; r++) begin
            do_start();
            for (int w = 0; w < N; w++)
                drive_window(G'($urandom), G'($urandom), 1'($urandom), 1'($urandom), -1);
            check_state("random_done", 3'b001);
        end

        // Abort on the fifth cycle of window 2, then abort beats start in IDLE.
        do_start();
        drive_window(G'($urandom), G'($urandom), 1'b0, 1'b0, -1);
        drive_window(G'($urandom), G'($urandom), 1'b0, 1'b0, 4);
        check_state("abort_idle", 3'b000);
        start = 1'b1; abort = 1'b1;
        @(negedge sys_clk);
        start = 1'b0; abort = 1'b0;
        repeat (2) @(negedge sys_clk);
        check_state("abort_wins", 3'b000);

        // Build last0=7, last1=8 and sweep the display select.
        do_start();
        for (int w = 0; w < N - 1; w++) drive_window(G'($urandom), G'($urandom), 1'b0, 1'b0, -1);
        p0 = 10'b0111111100;
        p1 = 10'b1101101111;
        drive_window(p0, p1, 1'b0, 1'b0, -1);
        check_state("led_setup", 3'b001);
        prev_led = led_model(0, 3'b010);
        for (int k = 1; k <= 8; k++) begin
            sw = 3'(k % 8);
            #1;
            check("led_latency", LED, prev_led);
            @(negedge sys_clk);
            prev_led = led_model(k % 8, 3'b010);
            check("led_select", LED, prev_led);
        end

        // Reset together with start, then reset in mid-window.
        sw = 3'd6;
        reset = 1'b1; start = 1'b1;
        @(negedge sys_clk);
        reset = 1'b0; start = 1'b0;
        model_clear();
        check_state("reset_with_start", 3'b000);
        check("reset_with_start_led", LED, 0);
        do_start();
        for (int c = 0; c < 5; c++) begin
            hit0 = 1'b1; hit1 = 1'b1;
            @(negedge sys_clk);
        end
        reset = 1'b1;
        @(negedge sys_clk);
        reset = 1'b0;
        check_state("reset_mid_window", 3'b000);
        repeat (G + 3) @(negedge sys_clk);
        hit0 = 1'b0; hit1 = 1'b0;
        check_state("no_latch_after_reset", 3'b000);
        check("no_latch_led", LED, 0);

        // Saturation of the window counter with a 300-cycle gate.
        s_start = 1'b1;
        @(negedge sys_clk);
        s_start = 1'b0;
        s_hit1  = 1'b1;
        repeat (GS + 1) @(negedge sys_clk);
        s_hit1 = 1'b0;
        @(negedge sys_clk);
        check("sat_status", {s_gate, s_busy, s_done}, 3'b001);
        check("sat_run_idx", s_run, 1);
        check("sat_last0", s_last0, 0);
        check("sat_last1", s_last1, 255);
        check("sat_total1", s_total1, 255);
        check("sat_led", s_led, 255);

        repeat (2) @(negedge sys_clk);
        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
